// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine: time-multiplexed forward/inverse AES SubBytes over a 128-bit state
// Ports:
//   clock, reset_n           rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready        input handshake; in_state (byte 0 = [127:120]) and in_inverse
//                            are sampled only on the accepting edge
//   out_valid/out_ready      output handshake; out_state/out_inverse stay stable until taken
//   busy                     high whenever the engine is not idle
module sub_bytes_engine #(
    parameter int LANES = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inverse,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         out_inverse,
    output logic         busy
);
    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0, as the S-box needs
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] t;
        logic [7:0] r;
        t = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            t = gmul(t, t);
            r = gmul(r, t);
        end
        return r;
    endfunction

    // One shared field inverter per lane: the affine maps sit on opposite sides per mode
    function automatic logic [7:0] sbox(input logic [7:0] x, input logic inv);
        logic [7:0] w;
        logic [7:0] g;
        w = inv ? ({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05) : x;
        g = ginv(w);
        return inv ? g : (g ^ {g[6:0], g[7]} ^ {g[5:0], g[7:6]} ^ {g[4:0], g[7:5]} ^ {g[3:0], g[7:4]} ^ 8'h63);
    endfunction

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [15:0][7:0]  r_src;
    logic [15:0][7:0]  r_res;
    logic              r_mode;
    logic              w_accept;
    logic [7:0]        w_sub [LANES];
    logic [3:0]        w_pos [LANES];

    // Byte b of the state lives in packed element 15-b
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign w_pos[j] = 4'(15 - (int'(r_cnt) * LANES + j));
        assign w_sub[j] = sbox(r_src[w_pos[j]], r_mode);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_src   <= '0;
            r_res   <= '0;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_src  <= in_state;
                r_mode <= in_inverse;
                r_cnt  <= '0;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt + CW'(1);
                for (int j = 0; j < LANES; j++) r_res[w_pos[j]] <= w_sub[j];
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        in_ready    = (r_state == IDLE) || (r_state == DONE && out_ready);
        w_accept    = in_valid && in_ready;
        out_valid   = r_state == DONE;
        busy        = r_state != IDLE;
        out_state   = r_res;
        out_inverse = r_mode;
        unique case (r_state)
            IDLE:    w_next = w_accept ? BUSY : IDLE;
            BUSY:    w_next = (r_cnt == CW'(N - 1)) ? DONE : BUSY;
            DONE:    w_next = out_ready ? (in_valid ? BUSY : IDLE) : DONE;
            default: w_next = IDLE;
        endcase
    end
endmodule

// File: doc/sub_bytes_engine.md
# sub_bytes_engine

Sequential, parametrised SubBytes unit for the AES round datapath. It performs the forward or inverse AES S-box substitution on a full 128-bit state using a configurable number of S-box lanes, time-multiplexed across the 16 bytes. The mode is selected per transaction, and ready/valid handshakes sit on both sides. It sits between the round-key/ShiftRows stages and replaces the purely combinational SubBytes/SubBytesInverse pair where S-box area must be traded for latency.

## Interface
Parameters:
- LANES, 4, number of parallel S-box lanes. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- N (localparam), 16/LANES, number of processing cycles per state.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input transaction valid.
- in_ready  output  1  engine can accept a state.
- in_state  input  128  state_t; byte 0 is [127:120] (FIPS-197 input order), byte 15 is [7:0].
- in_inverse  input  1  0 = forward S-box, 1 = inverse S-box.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_state  output  128  substituted state, same byte ordering as in_state.
- out_inverse  output  1  mode the result was computed with.
- busy  output  1  high in any state other than IDLE.

## Operation
- FSM with three states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_state into src, in_inverse into mode, clear cnt, go to BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each cycle, lane j processes byte cnt*LANES+j and writes its result into the same byte position of the res register.
  - cnt increments by 1 each cycle. When cnt==N-1 at the edge, go to DONE.
  - mode is held constant throughout BUSY.
- DONE:
  - out_valid=1, out_state=res, out_inverse=mode.
  - Hold all three stable while out_ready=0.
  - On out_valid&&out_ready with in_valid=0: go to IDLE.
  - On out_valid&&out_ready with in_valid=1: accept the new state in the same cycle (capture, cnt=0) and go to BUSY.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is a combinational path from out_ready only.
- Every lane uses the same mode. Forward and inverse tables match FIPS-197 Figure 7 and Figure 14 exactly.
- in_state and in_inverse are ignored except at the acceptance edge.
- The cnt register is $clog2(N) bits wide, with a minimum of 1 bit. When LANES=16, BUSY lasts exactly one cycle.
- The src register is read-only after capture. The res register is fully overwritten across the N cycles, so no clearing is required between transactions.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - state=IDLE, cnt=0, src=0, res=0, mode=0.
  - Outputs: in_ready=1, out_valid=0, out_state=0, out_inverse=0, busy=0.
- Latency: acceptance at edge k, then out_valid=1 after edge k+N.
- Throughput: one state per N+1 cycles with out_ready held at 1 and in_valid held at 1.
- Backpressure: out_valid, once asserted, stays high with out_state constant until the out_ready handshake. It never drops while out_ready=0.
- Reset asserted mid-BUSY or mid-DONE: the in-flight transaction is discarded, outputs go immediately to their reset values, and no partial result is ever presented.
- in_valid with in_ready=0 (BUSY, or DONE with out_ready=0): no capture. The producer must hold its data.

## Test plan
- Forward, LANES=4:
  - Stimulus: in_state=193de3bea0f4e22b9ac68d2ae9f84808, in_inverse=0, out_ready=1.
  - Response: out_state=d42711aee0bf98f1b8b45de51e415230 and out_inverse=0, exactly 4 cycles after acceptance.
- Inverse, LANES=1:
  - Stimulus: in_state=d42711aee0bf98f1b8b45de51e415230, in_inverse=1.
  - Response: out_state=193de3bea0f4e22b9ac68d2ae9f84808, with out_valid after 16 cycles.
- Byte corners, run at every legal LANES value:
  - Forward all-0x00 → all-0x63. Forward all-0xff → all-0x16.
  - Inverse all-0x00 → all-0x52. Inverse all-0x63 → all-0x00.
  - Latency must equal 16/LANES in each case.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE.
  - out_valid and out_state must stay stable, in_ready=0, and a held in_valid must not be accepted.
  - Raise out_ready with in_valid=1 and a mode flip: the next state is accepted in that same cycle and its result carries the new out_inverse.
- Back-to-back stream, LANES=8:
  - Stimulus: 20 random states with alternating mode.
  - Response: results match the combinational reference S-box, in order, with period 3 cycles.
- Reset mid-operation:
  - Deassert reset_n during cycle 2 of BUSY.
  - Outputs go to their reset values asynchronously; after release, a fresh transaction completes correctly with no stale res bytes.
